pwm_duty_ramp: RTL and testbench

Upstream companion to the PWM generator. It produces the `compare` (duty) value that the PWM generator consumes, and ramps that value from its current level to a requested target. Steps are of programmable size, taken every programmable number of PWM periods. Duty changes occur only at PWM period boundaries, so the downstream PWM never emits a truncated or glitched pulse. Typical use: LED fade, soft-start of motor drive.

---
 rtl/pwm_duty_ramp.sv | 175 +++++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// pwm_duty_ramp
//
// Produces the duty (compare) value for a downstream PWM generator and ramps
// it from the current level to a requested target. The ramp moves by a
// programmable step once every (rate+1) PWM periods. compare is only updated
// on the PWM period boundary, so the PWM never emits a truncated pulse.
//
// Optional build macro:
//   DUTY_RAMP_GAMMA_EN - when defined, compare = (level*level) >> CTR_LEN,
//                        with level == all-ones mapping to all-ones. This
//                        gives a perceptually linear LED fade. When not
//                        defined, compare = level and no multiplier exists.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   target        requested final duty
//   step          increment per step (0 behaves as 1)
//   rate          PWM periods between steps, minus 1
//   target_valid  command valid
//   target_ready  command can be accepted (IDLE and not in reset)
//   compare       registered duty to the PWM generator
//   busy          ramp in progress
//   done          one-cycle pulse when the target has been reached
// -----------------------------------------------------------------------------
module pwm_duty_ramp #(
    parameter int CTR_LEN = 8,
    parameter int DIV_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CTR_LEN-1:0] target,
    input  logic [CTR_LEN-1:0] step,
    input  logic [DIV_LEN-1:0] rate,
    input  logic               target_valid,
    output logic               target_ready,
    output logic [CTR_LEN-1:0] compare,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CTR_LEN-1:0] per_q, per_d;
    logic [CTR_LEN-1:0] level_q, level_d;
    logic [CTR_LEN-1:0] cmp_q, cmp_d;
    logic [DIV_LEN-1:0] div_q, div_d;
    logic [CTR_LEN-1:0] tgt_q, tgt_d;
    logic [CTR_LEN-1:0] step_q, step_d;
    logic [DIV_LEN-1:0] rate_q, rate_d;
    logic               done_q, done_d;

    logic               period_end;
    logic               accept;
    logic [CTR_LEN:0]   gap;
    logic [CTR_LEN:0]   step_ext;

    // Maps the ramp level onto the duty actually driven to the PWM.
    function automatic logic [CTR_LEN-1:0] shape(input logic [CTR_LEN-1:0] lvl);
`ifdef DUTY_RAMP_GAMMA_EN
        logic [2*CTR_LEN-1:0] prod;
        prod = {{CTR_LEN{1'b0}}, lvl} * {{CTR_LEN{1'b0}}, lvl};
        // Squaring alone tops out below full scale; force the end point.
        if (lvl == {CTR_LEN{1'b1}}) begin
            return {CTR_LEN{1'b1}};
        end
        return prod[2*CTR_LEN-1:CTR_LEN];
`else
        return lvl;
`endif
    endfunction

    assign period_end   = (per_q == {CTR_LEN{1'b1}});
    assign target_ready = (state_q == IDLE) && !rst;
    assign accept       = target_valid && target_ready;

    // Distance still to travel, one bit wider so the comparison with the
    // step never wraps.
    assign gap      = (state_q == UP) ? ({1'b0, tgt_q} - {1'b0, level_q})
                                      : ({1'b0, level_q} - {1'b0, tgt_q});
    assign step_ext = {1'b0, step_q};

    always_comb begin
        state_d = state_q;
        per_d   = per_q + 1'b1;
        level_d = level_q;
        div_d   = div_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        rate_d  = rate_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d  = target;
                    step_d = (step == '0) ? {{(CTR_LEN-1){1'b0}}, 1'b1} : step;
                    rate_d = rate;
                    div_d  = rate;
                    if (target > level_q) begin
                        state_d = UP;
                    end else if (target < level_q) begin
                        state_d = DOWN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            UP, DOWN: begin
                if (period_end) begin
                    if (div_q == '0) begin
                        div_d = rate_q;
                        // gap > step guarantees the add/subtract stays in range.
                        if (gap <= step_ext) begin
                            level_d = tgt_q;
                        end else if (state_q == UP) begin
                            level_d = level_q + step_q;
                        end else begin
                            level_d = level_q - step_q;
                        end
                        if (level_d == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q - {{(DIV_LEN-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // compare takes the freshly written level on the same period edge,
        // so the new duty starts exactly when the PWM counter wraps to 0.
        cmp_d = period_end ? shape(level_d) : cmp_q;
    end

    // State / datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            level_q <= '0;
            cmp_q   <= '0;
            div_q   <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            rate_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            level_q <= level_d;
            cmp_q   <= cmp_d;
            div_q   <= div_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            rate_q  <= rate_d;
            done_q  <= done_d;
        end
    end

    assign compare = cmp_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_ramp
//
// Self-checking bench for pwm_duty_ramp (CTR_LEN=8, DIV_LEN=16). A
// transaction-level reference model precomputes the list of levels a command
// will walk through and releases one entry every (rate+1) period ends; every
// cycle the DUT outputs are compared against it. Honours DUTY_RAMP_GAMMA_EN.
// -----------------------------------------------------------------------------
module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  target;
    logic [7:0]  step;
    logic [15:0] rate;
    logic        target_valid;
    logic        target_ready;
    logic [7:0]  compare;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pwm_duty_ramp #(
        .CTR_LEN(8),
        .DIV_LEN(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .target      (target),
        .step        (step),
        .rate        (rate),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .compare     (compare),
        .busy        (busy),
        .done        (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_per   = 0;
    int m_level = 0;
    int m_cmp   = 0;
    int m_busy  = 0;
    int m_done  = 0;
    int m_rate  = 0;
    int m_pe    = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    function automatic int shape(input int lvl);
`ifdef DUTY_RAMP_GAMMA_EN
        if (lvl == 255) return 255;
        return (lvl * lvl) / 256;
`else
        return lvl;
`endif
    endfunction

    // One clock edge: advance the model with the inputs present at the edge,
    // then check the DUT just after the edge.
    task automatic tick();
        logic r, tv;
        int   t, s, rt, pe, lv;
        r  = rst;
        tv = target_valid;
        t  = int'(target);
        s  = (step == 8'd0) ? 1 : int'(step);
        rt = int'(rate);
        @(posedge clk);
        pe = (m_per == 255) ? 1 : 0;
        if (r) begin
            m_per = 0; m_level = 0; m_cmp = 0; m_busy = 0; m_done = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            if (m_busy == 0 && tv) begin
                exp_q.delete();
                lv = m_level;
                while (lv != t) begin
                    if (t > lv) lv = (t - lv <= s) ? t : lv + s;
                    else        lv = (lv - t <= s) ? t : lv - s;
                    exp_q.push_back(lv);
                end
                if (exp_q.size() == 0) begin
                    m_done = 1;
                end else begin
                    m_busy = 1;
                    m_pe   = 0;
                    m_rate = rt;
                end
            end else if (m_busy != 0 && pe != 0) begin
                m_pe++;
                if (m_pe % (m_rate + 1) == 0) begin
                    m_level = exp_q.pop_front();
                    if (exp_q.size() == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
            if (pe != 0) m_cmp = shape(m_level);
            m_per = (m_per + 1) % 256;
        end
        #1;
        chk("compare", 32'(compare), 32'(m_cmp));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("target_ready", 32'(target_ready), (m_busy == 0 && !rst) ? 32'd1 : 32'd0);
        // Inputs wiggle freely while no command is offered; must not matter.
        if (!target_valid) begin
            target = 8'($urandom_range(0, 255));
            step   = 8'($urandom_range(0, 255));
            rate   = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic cmd(input int t, input int s, input int r);
        target       = 8'(t);
        step         = 8'(s);
        rate         = 16'(r);
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && (m_busy != 0 || busy); i++) tick();
        chk("idle_reached", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        int t, s, d, smin;
        rst          = 1'b1;
        target       = 8'd0;
        step         = 8'd0;
        rate         = 16'd0;
        target_valid = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        #0;
        chk("ready_after_rst", 32'(target_ready), 32'd1);
        tick();

        // Ramp up from 0 in steps of 10
        cmd(100, 10, 0);
        wait_idle();
        chk("ramp_up_final", 32'(compare), 32'(shape(100)));

        // Clamp at the top
        cmd(240, 240, 0); wait_idle();
        cmd(255, 20, 0);  wait_idle();
        chk("clamp_top", 32'(compare), 32'(shape(255)));

        // Clamp at the bottom
        cmd(100, 200, 0); wait_idle();
        cmd(5, 20, 0);    wait_idle();
        chk("clamp_bottom", 32'(compare), 32'(shape(5)));

        // Divider with step 0
        cmd(0, 255, 0);   wait_idle();
        cmd(2, 0, 3);     wait_idle();
        chk("div_step0", 32'(compare), 32'(shape(2)));

        // Equal target
        cmd(2, 7, 0);
        chk("eq_done", 32'(done), 32'd1);
        chk("eq_busy", 32'(busy), 32'd0);
        tick();
        chk("eq_done_clear", 32'(done), 32'd0);

        // Second command mid-ramp is ignored
        cmd(100, 20, 0);
        for (int i = 0; i < 300; i++) tick();
        target       = 8'd7;
        step         = 8'd1;
        rate         = 16'd9;
        target_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        target_valid = 1'b0;
        wait_idle();
        chk("ignore_mid_cmd", 32'(compare), 32'(shape(100)));

        // Reset mid-ramp at level 60
        cmd(0, 255, 0); wait_idle();
        cmd(100, 20, 0);
        for (int i = 0; i < 2000 && m_level != 60; i++) tick();
        chk("reached_60", 32'(m_level), 32'd60);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_cmp", 32'(compare), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 600; i++) tick();

        // Shaping points
        cmd(128, 255, 0); wait_idle();
`ifdef DUTY_RAMP_GAMMA_EN
        chk("shape_128", 32'(compare), 32'd64);
`else
        chk("shape_128", 32'(compare), 32'd128);
`endif
        cmd(255, 255, 0); wait_idle();
        chk("shape_255", 32'(compare), 32'd255);

        // Randomised commands, sized to finish within a few steps
        for (int k = 0; k < 10; k++) begin
            t    = int'($urandom_range(0, 255));
            d    = (t > m_level) ? t - m_level : m_level - t;
            smin = (d == 0) ? 0 : (d + 5) / 6;
            s    = int'($urandom_range(smin, 255));
            if (s == 0 && d > 6) s = smin;
            cmd(t, s, int'($urandom_range(0, 1)));
            wait_idle();
            chk("rand_final", 32'(compare), 32'(shape(t)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
